nn_config_loader: RTL and testbench
===================================

NN_CONFIG_LOADER -- requirements
Module: nn_config_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of the config word and the weight/bias values.
REQ-002 SHALL have parameters NW1/NN1, NW2/NN2, NW3/NN3, defaults 784/30, 30/30, 30/10, meaning weights per neuron / neurons for layers 1..3.
REQ-003 SHALL have ports: s_axi_aclk in 1 clock; s_axi_aresetn in 1 asynchronous active-low reset.
REQ-004 SHALL have ports: start in 1 begin load pulse; abort in 1 cancel load.
REQ-005 SHALL have ports: cfg_data in DATA_WIDTH source word; cfg_valid in 1 source word valid; cfg_ready out 1 loader accepts word.
REQ-006 SHALL have ports: layer_num out 32 target layer (1..3); neuron_num out 32 target neuron (0-based).
REQ-007 SHALL have ports: weight_value out DATA_WIDTH; weight_valid out 1; bias_value out DATA_WIDTH; bias_valid out 1.
REQ-008 SHALL have ports: busy out 1 load in progress; done out 1 one-cycle completion pulse; word_count out 32 words accepted in the current load.

Function
REQ-009 SHALL implement states IDLE, WEIGHT, BIAS, DONE.
REQ-010 IDLE: start=1 -> WEIGHT; layer index=1, neuron index=0, weight index=0, word_count=0.
REQ-011 Accept = cfg_valid && cfg_ready; cfg_ready SHALL be 1 only in WEIGHT or BIAS with abort=0 (combinational).
REQ-012 WEIGHT: each accept increments weight index; the accept at index NW(L)-1 SHALL move to BIAS and clear the weight index.
REQ-013 BIAS: one accept SHALL return to WEIGHT with neuron+1. If neuron was NN(L)-1, it SHALL set neuron=0 and layer+1. If layer was 3, it SHALL move to DONE.
REQ-014 Each accept SHALL produce, in the next cycle, a 1-cycle weight_valid (WEIGHT) or bias_valid (BIAS). The value output SHALL equal the accepted word, and layer_num/neuron_num SHALL equal that word's indices. Latency is exactly 1 cycle.
REQ-015 weight_value, bias_value, layer_num and neuron_num SHALL hold their last value when not pulsing. weight_valid and bias_valid SHALL never both be 1.
REQ-016 Back-to-back accepts SHALL be supported at one word per cycle, with no bubbles at weight->bias or neuron/layer boundaries.
REQ-017 cfg_valid=0 stalls SHALL leave all indices unchanged. No pulse SHALL be emitted during a stall.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE. done SHALL be asserted in the cycle after the final bias_valid pulse.
REQ-019 busy SHALL be 1 in WEIGHT, BIAS and DONE, and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 abort=1 in WEIGHT or BIAS SHALL force IDLE next cycle. No word is accepted in that cycle, done is not asserted, and all indices are cleared.
REQ-022 A pulse from an accept in the cycle before abort SHALL still be emitted.
REQ-023 abort in IDLE or DONE SHALL have no effect; DONE completes normally.
REQ-024 word_count SHALL increment on every accept. It SHALL hold its value after DONE or abort until the next start.
REQ-025 Total words per load SHALL be sum over L of NN(L)*(NW(L)+1).

Reset
REQ-026 Asserting s_axi_aresetn=0 SHALL immediately, without waiting for a clock, set: state IDLE; cfg_ready, weight_valid, bias_valid, busy, done all 0; layer_num, neuron_num, weight_value, bias_value, word_count all 0.
REQ-027 Reset mid-load SHALL discard all progress. No output pulse SHALL occur until the next start after reset release.

Verification (params NW1=3,NN1=2,NW2=2,NN2=2,NW3=2,NN3=1)
REQ-028 Full load: start, then 17 words 1..17 streamed with cfg_valid=1 continuously -> required response:
- weight pulses for words 1,2,3 at (L1,N0); bias 4 at (L1,N0); words 5-7 weights at (L1,N1); bias 8;
- words 9,10 weights at (L2,N0); bias 11; words 12,13 weights at (L2,N1); bias 14;
- words 15,16 weights at (L3,N0); bias 17;
- done one cycle after the bias-17 pulse; word_count=17.
REQ-029 Stalls: same stream with cfg_valid toggled 1/0 every cycle -> identical pulse sequence and indices, with 1-cycle gaps between pulses; done after the bias-17 pulse.
REQ-030 Abort: abort asserted at the cycle word 6 is offered -> word 6 not accepted; pulses 1-5 only; busy=0 next cycle; no done; word_count=5.
REQ-031 Start ignored: start pulsed again at word 10 -> indices unaffected; load completes normally with word_count=17.
REQ-032 Reset mid-load: s_axi_aresetn=0 after word 8 -> all outputs 0 immediately; after release, a new start plus 17 words repeats the REQ-028 sequence exactly.

Source files
------------

// File: rtl/nn_config_loader.sv
// Streams a flat config word sequence into per-layer weight/bias writes for a 3-layer network.
// Each accepted word is re-emitted one cycle later with its layer/neuron coordinates.
module nn_config_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NW1        = 784,
    parameter int NN1        = 30,
    parameter int NW2        = 30,
    parameter int NN2        = 30,
    parameter int NW3        = 30,
    parameter int NN3        = 10
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [31:0]           layer_num,
    output logic [31:0]           neuron_num,
    output logic [DATA_WIDTH-1:0] weight_value,
    output logic                  weight_valid,
    output logic [DATA_WIDTH-1:0] bias_value,
    output logic                  bias_valid,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           word_count
);

    typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  lay;
    logic [31:0] nrn;
    logic [31:0] wgt;
    logic        accept;
    logic        last_weight;
    logic        last_neuron;

    function automatic logic [31:0] nw_of(input logic [1:0] l);
        case (l)
            2'd1:    nw_of = 32'(NW1);
            2'd2:    nw_of = 32'(NW2);
            default: nw_of = 32'(NW3);
        endcase
    endfunction

    function automatic logic [31:0] nn_of(input logic [1:0] l);
        case (l)
            2'd1:    nn_of = 32'(NN1);
            2'd2:    nn_of = 32'(NN2);
            default: nn_of = 32'(NN3);
        endcase
    endfunction

    assign cfg_ready   = ((state == WEIGHT) || (state == BIAS)) && !abort;
    assign accept      = cfg_valid && cfg_ready;
    assign busy        = (state != IDLE);
    assign last_weight = (wgt == nw_of(lay) - 32'd1);
    assign last_neuron = (nrn == nn_of(lay) - 32'd1);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = WEIGHT;
            end
            WEIGHT: begin
                if (abort)                       state_nxt = IDLE;
                else if (accept && last_weight)  state_nxt = BIAS;
            end
            BIAS: begin
                if (abort)       state_nxt = IDLE;
                else if (accept) state_nxt = (last_neuron && (lay == 2'd3)) ? DONE : WEIGHT;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output stage: accepted word plus its coordinates, valid one cycle after the handshake
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            lay          <= 2'd0;
            nrn          <= '0;
            wgt          <= '0;
            word_count   <= '0;
            layer_num    <= '0;
            neuron_num   <= '0;
            weight_value <= '0;
            bias_value   <= '0;
            weight_valid <= 1'b0;
            bias_valid   <= 1'b0;
            done         <= 1'b0;
        end else begin
            weight_valid <= 1'b0;
            bias_valid   <= 1'b0;
            done         <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        lay        <= 2'd1;
                        nrn        <= '0;
                        wgt        <= '0;
                        word_count <= '0;
                    end
                end
                WEIGHT, BIAS: begin
                    if (abort) begin
                        lay <= 2'd0;
                        nrn <= '0;
                        wgt <= '0;
                    end else if (accept) begin
                        word_count <= word_count + 32'd1;
                        layer_num  <= {30'd0, lay};
                        neuron_num <= nrn;
                        if (state == WEIGHT) begin
                            weight_value <= cfg_data;
                            weight_valid <= 1'b1;
                            wgt          <= last_weight ? 32'd0 : wgt + 32'd1;
                        end else begin
                            bias_value <= cfg_data;
                            bias_valid <= 1'b1;
                            if (last_neuron) begin
                                nrn <= '0;
                                lay <= lay + 2'd1;
                            end else begin
                                nrn <= nrn + 32'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_config_loader.sv
// Bench for nn_config_loader: per-cycle reference model plus literal checks of the small-network load order.
module tb_nn_config_loader;

    localparam int DW    = 32;
    localparam int NW1   = 3, NN1 = 2, NW2 = 2, NN2 = 2, NW3 = 2, NN3 = 1;
    localparam int TOTAL = NN1*(NW1+1) + NN2*(NW2+1) + NN3*(NW3+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [31:0]   layer_num, neuron_num, word_count;
    logic [DW-1:0] weight_value, bias_value;
    logic          weight_valid, bias_valid, busy, done;

    nn_config_loader #(
        .DATA_WIDTH(DW), .NW1(NW1), .NN1(NN1), .NW2(NW2), .NN2(NN2), .NW3(NW3), .NN3(NN3)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .layer_num(layer_num), .neuron_num(neuron_num),
        .weight_value(weight_value), .weight_valid(weight_valid),
        .bias_value(bias_value), .bias_valid(bias_valid),
        .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected load order derived from the layer/neuron/weight nesting rules
    int seq_kind[TOTAL];
    int seq_lay[TOTAL];
    int seq_nrn[TOTAL];

    int          ph = 0, pos = 0, m_wc = 0;
    bit          e_wv = 0, e_bv = 0, e_done = 0;
    logic [31:0] m_wval = 0, m_bval = 0, m_lay = 0, m_nrn = 0;

    initial begin
        int k;
        int nws[3];
        int nns[3];
        nws = '{NW1, NW2, NW3};
        nns = '{NN1, NN2, NN3};
        k = 0;
        for (int l = 0; l < 3; l++)
            for (int n = 0; n < nns[l]; n++)
                for (int w = 0; w <= nws[l]; w++) begin
                    seq_kind[k] = (w == nws[l]) ? 1 : 0;
                    seq_lay[k]  = l + 1;
                    seq_nrn[k]  = n;
                    k++;
                end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_cfg_ready", 32'(cfg_ready), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_pulses", 32'({weight_valid, bias_valid, done}), 0);
                chk("rst_word_count", word_count, 0);
                ph = 0; pos = 0; m_wc = 0; e_wv = 0; e_bv = 0; e_done = 0;
                m_wval = 0; m_bval = 0; m_lay = 0; m_nrn = 0;
            end else begin
                chk("cfg_ready", 32'(cfg_ready), 32'(ph == 1 && !abort));
                chk("busy", 32'(busy), 32'(ph != 0));
                chk("weight_valid", 32'(weight_valid), 32'(e_wv));
                chk("bias_valid", 32'(bias_valid), 32'(e_bv));
                chk("done", 32'(done), 32'(e_done));
                chk("word_count", word_count, m_wc);
                chk("weight_value", weight_value, m_wval);
                chk("bias_value", bias_value, m_bval);
                chk("layer_num", layer_num, m_lay);
                chk("neuron_num", neuron_num, m_nrn);
                e_wv = 0; e_bv = 0; e_done = 0;
                case (ph)
                    0: if (start) begin ph = 1; pos = 0; m_wc = 0; end
                    1: begin
                        if (abort) begin
                            ph = 0;
                        end else if (cfg_valid) begin
                            if (seq_kind[pos] == 1) begin e_bv = 1; m_bval = pos + 1; end
                            else begin e_wv = 1; m_wval = pos + 1; end
                            m_lay = seq_lay[pos];
                            m_nrn = seq_nrn[pos];
                            m_wc++;
                            pos++;
                            if (pos == TOTAL) ph = 2;
                        end
                    end
                    default: begin e_done = 1; ph = 0; end
                endcase
            end
        end
    end

    // Pulse log for literal comparison against the hand-written load order
    int log_val[$];
    int log_kind[$];
    int log_lay[$];
    int log_nrn[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (weight_valid) begin
                log_val.push_back(int'(weight_value)); log_kind.push_back(0);
                log_lay.push_back(int'(layer_num));   log_nrn.push_back(int'(neuron_num));
            end
            if (bias_valid) begin
                log_val.push_back(int'(bias_value));  log_kind.push_back(1);
                log_lay.push_back(int'(layer_num));   log_nrn.push_back(int'(neuron_num));
            end
            if (done) done_cnt++;
        end
    end

    int lit_kind[17] = '{0,0,0,1, 0,0,0,1, 0,0,1, 0,0,1, 0,0,1};
    int lit_lay[17]  = '{1,1,1,1, 1,1,1,1, 2,2,2, 2,2,2, 3,3,3};
    int lit_nrn[17]  = '{0,0,0,0, 1,1,1,1, 0,0,0, 1,1,1, 0,0,0};

    task automatic check_log(input string tag, input int n);
        chk({tag, "_pulse_count"}, 32'(log_val.size()), 32'(n));
        for (int i = 0; i < n && i < log_val.size(); i++) begin
            chk($sformatf("%s_val%0d", tag, i + 1), 32'(log_val[i]), 32'(i + 1));
            chk($sformatf("%s_kind%0d", tag, i + 1), 32'(log_kind[i]), 32'(lit_kind[i]));
            chk($sformatf("%s_layer%0d", tag, i + 1), 32'(log_lay[i]), 32'(lit_lay[i]));
            chk($sformatf("%s_neuron%0d", tag, i + 1), 32'(log_nrn[i]), 32'(lit_nrn[i]));
        end
    endtask

    task automatic run_load(input bit stall, input int abort_at, input int start_at,
                            input int stop_after, output int accepted);
        int w;
        int cyc;
        bit acc;
        bit quit;
        w = 1; cyc = 0; quit = 0;
        log_val.delete(); log_kind.delete(); log_lay.delete(); log_nrn.delete();
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!quit && w <= TOTAL && cyc < 200) begin
            cfg_data  = w;
            cfg_valid = stall ? (cyc % 2 == 0) : 1'b1;
            abort     = (w == abort_at);
            start     = (w == start_at);
            @(negedge clk);
            acc = cfg_valid && cfg_ready;
            @(posedge clk); #1;
            if (abort) quit = 1;
            if (acc) w++;
            if (stop_after > 0 && w > stop_after) quit = 1;
            cyc++;
        end
        cfg_valid = 1'b0; abort = 1'b0; start = 1'b0;
        accepted = w - 1;
        if (!quit && w <= TOTAL) begin
            checks++; errors++;
            $display("FAIL load_timeout: accepted %0d words, required %0d", w - 1, TOTAL);
        end
    endtask

    initial begin
        int acc_n;
        #1 rst_n = 1'b0;
        #1;
        chk("init_busy", 32'(busy), 0);
        chk("init_word_count", word_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // abort while idle must do nothing
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);

        run_load(0, 0, 0, 0, acc_n);
        repeat (4) @(posedge clk); #1;
        chk("full_word_count", word_count, 17);
        chk("full_done_cnt", 32'(done_cnt), 1);
        check_log("full", 17);

        run_load(1, 0, 0, 0, acc_n);
        repeat (4) @(posedge clk); #1;
        chk("stall_word_count", word_count, 17);
        chk("stall_done_cnt", 32'(done_cnt), 1);
        check_log("stall", 17);

        run_load(0, 6, 0, 0, acc_n);
        chk("abort_busy", 32'(busy), 0);
        repeat (4) @(posedge clk); #1;
        chk("abort_word_count", word_count, 5);
        chk("abort_done_cnt", 32'(done_cnt), 0);
        check_log("abort", 5);

        run_load(0, 0, 10, 0, acc_n);
        repeat (4) @(posedge clk); #1;
        chk("restart_word_count", word_count, 17);
        chk("restart_done_cnt", 32'(done_cnt), 1);
        check_log("restart", 17);

        run_load(0, 0, 0, 8, acc_n);
        chk("pre_reset_word_count", word_count, 8);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_cfg_ready", 32'(cfg_ready), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_bias_valid", 32'(bias_valid), 0);
        chk("async_rst_weight_valid", 32'(weight_valid), 0);
        chk("async_rst_done", 32'(done), 0);
        chk("async_rst_word_count", word_count, 0);
        chk("async_rst_layer", layer_num, 0);
        chk("async_rst_neuron", neuron_num, 0);
        chk("async_rst_wval", weight_value, 0);
        chk("async_rst_bval", bias_value, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("post_reset_no_pulse", 32'({weight_valid, bias_valid, done}), 0);

        run_load(0, 0, 0, 0, acc_n);
        repeat (4) @(posedge clk); #1;
        chk("after_reset_word_count", word_count, 17);
        chk("after_reset_done_cnt", 32'(done_cnt), 1);
        check_log("after_reset", 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
